booth_product_accumulator: RTL and testbench

//  Downstream consumer of the 4x4 signed Booth multiplier: takes its 8-bit signed products over a valid/ready

---
 rtl/booth_pkg.sv | 15 +
 rtl/booth_product_accumulator_sat_add.sv | 35 +++
 rtl/booth_product_accumulator.sv | 164 ++++++++++++++++
 tb/tb_booth_product_accumulator.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Package booth_pkg
//   Definitions shared by the Booth product accumulator and the multiplier bench:
//   default product width, width of the term counter, and the accumulator FSM
//   state type.
package booth_pkg;

  localparam int PROD_W_DEF = 8;  // 4x4 signed multiplier result width
  localparam int CNT_W      = 8;  // term counter / acc_cnt width (NTERMS <= 255)

  typedef enum logic [0:0] {
    ACCUM = 1'b0,  // collecting products
    HOLD  = 1'b1   // finished sum presented, waiting for the sink
  } acc_state_t;

endpackage

// File: rtl/booth_product_accumulator_sat_add.sv
// Module: sat_add
//   Signed W-bit adder evaluated at W+1 bits and clamped back into the W-bit
//   two's complement range. ovf is high whenever the clamp changed the result.
//   Compiled only when the ACC_SAT_EN macro is defined.
// Ports
//   a, b  in   W  signed addends
//   sum   out  W  clamped signed sum
//   ovf   out  1  clamp applied
`ifdef ACC_SAT_EN
module sat_add #(
  parameter int W = 12
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                ovf
);

  logic signed [W:0] wide;

  assign wide = (W+1)'(a) + (W+1)'(b);

  // The W+1 bit result fits in W bits exactly when its top two bits agree.
  // A 0/1 pattern is positive overflow, 1/0 is negative overflow.
  always_comb begin
    sum = wide[W-1:0];
    ovf = 1'b0;
    if (wide[W] != wide[W-1]) begin
      ovf = 1'b1;
      sum = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
  end

endmodule
`endif

// File: rtl/booth_product_accumulator.sv
// Module: booth_product_accumulator
//   Sums runs of NTERMS signed products arriving over a valid/ready stream and
//   presents each finished sum on an output valid/ready port, holding it until
//   the sink takes it. A flush pulse ends a non-empty run early.
//   Optional feature macro: ACC_SAT_EN -- saturating accumulation with a sticky
//   per-run overflow flag on acc_ovf. Without it sums wrap and acc_ovf is 0.
// Ports
//   clk         in   1       rising-edge clock
//   rst_n       in   1       synchronous reset, active-low
//   prod_valid  in   1       product present on prod_data
//   prod_data   in   PROD_W  signed product
//   prod_ready  out  1       product accepted this cycle when valid
//   flush       in   1       end the current run early
//   acc_valid   out  1       finished sum on acc_data
//   acc_data    out  ACC_W   signed sum
//   acc_cnt     out  8       number of terms in acc_data
//   acc_ready   in   1       sink takes the sum
//   acc_ovf     out  1       run overflowed (ACC_SAT_EN only)
module booth_product_accumulator
  import booth_pkg::*;
#(
  parameter int PROD_W = PROD_W_DEF,
  parameter int NTERMS = 4,
  parameter int ACC_W  = 12
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     prod_valid,
  input  logic signed [PROD_W-1:0] prod_data,
  output logic                     prod_ready,
  input  logic                     flush,
  output logic                     acc_valid,
  output logic signed [ACC_W-1:0]  acc_data,
  output logic [CNT_W-1:0]         acc_cnt,
  input  logic                     acc_ready,
  output logic                     acc_ovf
);

  acc_state_t state, state_next;

  logic signed [ACC_W-1:0] acc;
  logic [CNT_W-1:0]        cnt;

  logic signed [ACC_W-1:0] prod_ext;
  logic signed [ACC_W-1:0] sum_next;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    take;
  logic                    emit;

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  // Size cast of a signed operand sign-extends it to the accumulator width.
  assign prod_ext = ACC_W'(prod_data);
  assign cnt_inc  = cnt + CNT_W'(1);
  assign take     = prod_valid & prod_ready;

  // A run ends when the accepted term completes it, or on flush if the run
  // (including a term accepted on the same edge) is non-empty.
  assign emit = (state == ACCUM) &&
                ((take && (cnt_inc == CNT_W'(NTERMS))) ||
                 (flush && (take || (cnt != '0))));

`ifdef ACC_SAT_EN
  logic add_ovf;

  sat_add #(
    .W (ACC_W)
  ) u_sat_add (
    .a   (acc),
    .b   (prod_ext),
    .sum (sum_next),
    .ovf (add_ovf)
  );
`else
  assign sum_next = acc + prod_ext;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every flop samples the
  // pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      ACCUM: if (emit)      state_next = HOLD;
      HOLD:  if (acc_ready) state_next = ACCUM;
      default:              state_next = ACCUM;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. prod_ready depends only on state, never on prod_valid.
  // ---------------------------------------------------------------------------
  always_comb begin
    prod_ready = 1'b0;
    if (state == ACCUM) prod_ready = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Accumulator and result registers
  // ---------------------------------------------------------------------------
  // NOTE: there are no memories here, so every register is reset; this keeps
  // the held result defined and drops any partial run on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      acc_valid <= 1'b0;
      acc_data  <= '0;
      acc_cnt   <= '0;
    end else begin
      if (emit) begin
        // A term accepted on the emitting edge is part of the emitted sum.
        acc_data  <= take ? sum_next : acc;
        acc_cnt   <= take ? cnt_inc  : cnt;
        acc_valid <= 1'b1;
        acc       <= '0;
        cnt       <= '0;
      end else begin
        if (take) begin
          acc <= sum_next;
          cnt <= cnt_inc;
        end
        if (state == HOLD && acc_ready) acc_valid <= 1'b0;
      end
    end
  end

`ifdef ACC_SAT_EN
  logic run_ovf;
  logic ovf_q;

  // run_ovf collects clamps of the run in progress; ovf_q is the copy that
  // travels with the emitted sum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run_ovf <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (emit) begin
      ovf_q   <= run_ovf | (take & add_ovf);
      run_ovf <= 1'b0;
    end else if (take) begin
      run_ovf <= run_ovf | add_ovf;
    end
  end

  assign acc_ovf = ovf_q;
`else
  assign acc_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_booth_product_accumulator.sv
// Bench for booth_product_accumulator (NTERMS=4, ACC_W=8 so that wrapping or
// clamping is reachable). A behavioural model tracks the current run as plain
// integers and is compared with the DUT outputs on every falling edge;
// directed runs additionally pin hand-computed sums. Honours ACC_SAT_EN.
module tb_booth_product_accumulator;
  import booth_pkg::*;

  localparam int PROD_W = 8;
  localparam int NTERMS = 4;
  localparam int ACC_W  = 8;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     prod_valid = 1'b0;
  logic signed [PROD_W-1:0] prod_data = '0;
  logic                     prod_ready;
  logic                     flush = 1'b0;
  logic                     acc_valid;
  logic signed [ACC_W-1:0]  acc_data;
  logic [CNT_W-1:0]         acc_cnt;
  logic                     acc_ready = 1'b1;
  logic                     acc_ovf;

  int checks = 0;
  int errors = 0;

  booth_product_accumulator #(
    .PROD_W (PROD_W),
    .NTERMS (NTERMS),
    .ACC_W  (ACC_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prod_valid (prod_valid),
    .prod_data  (prod_data),
    .prod_ready (prod_ready),
    .flush      (flush),
    .acc_valid  (acc_valid),
    .acc_data   (acc_data),
    .acc_cnt    (acc_cnt),
    .acc_ready  (acc_ready),
    .acc_ovf    (acc_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a run is an integer sum plus a term count; a result is
  // held until the sink is ready.
  // ---------------------------------------------------------------------------
  function automatic int model_add(input int s, input int p, output bit o);
    int r;
    int lo, hi, m;
    lo = -(1 << (ACC_W - 1));
    hi = (1 << (ACC_W - 1)) - 1;
    m  = 1 << ACC_W;
    r  = s + p;
    o  = 1'b0;
`ifdef ACC_SAT_EN
    if (r > hi) begin r = hi; o = 1'b1; end
    if (r < lo) begin r = lo; o = 1'b1; end
`else
    r = ((r % m) + m) % m;
    if (r > hi) r = r - m;
`endif
    return r;
  endfunction

  bit m_hold = 0;
  int m_sum = 0;
  int m_cnt = 0;
  bit m_ovf = 0;
  bit e_valid = 0;
  int e_data = 0;
  int e_cnt = 0;
  bit e_ovf = 0;
  int m_runs = 0;
  int m_terms = 0;
  int dut_in = 0;
  int dut_out = 0;

  always @(posedge clk) begin : model
    int s, c;
    bit o, a;
    // DUT-side handshake counters for the conservation check.
    if (rst_n) begin
      if (prod_valid && prod_ready) dut_in <= dut_in + 1;
      if (acc_valid && acc_ready)   dut_out <= dut_out + int'(acc_cnt);
    end
    if (!rst_n) begin
      m_hold <= 0; m_sum <= 0; m_cnt <= 0; m_ovf <= 0;
      e_valid <= 0; e_data <= 0; e_cnt <= 0; e_ovf <= 0;
      dut_in <= 0; dut_out <= 0; m_terms <= 0;
    end else if (m_hold) begin
      if (acc_ready) begin
        m_hold  <= 0;
        e_valid <= 0;
        m_runs  <= m_runs + 1;
      end
    end else begin
      s = m_sum; c = m_cnt; o = m_ovf;
      if (prod_valid) begin
        s = model_add(s, int'(prod_data), a);
        o = o | a;
        c = c + 1;
        m_terms <= m_terms + 1;
      end
      if (c == NTERMS || (flush && c > 0)) begin
        e_valid <= 1; e_data <= s; e_cnt <= c; e_ovf <= o;
        m_hold <= 1; m_sum <= 0; m_cnt <= 0; m_ovf <= 0;
      end else begin
        m_sum <= s; m_cnt <= c; m_ovf <= o;
      end
    end
  end

  bit cmp_on = 0;

  always @(negedge clk) begin
    if (cmp_on) begin
      check("cyc_prod_ready", prod_ready, !m_hold);
      check("cyc_acc_valid", acc_valid, e_valid);
      check("cyc_acc_data", acc_data, e_data);
      check("cyc_acc_cnt", acc_cnt, e_cnt);
      check("cyc_acc_ovf", acc_ovf, e_ovf);
    end
  end

  // ---------------------------------------------------------------------------
  // Drivers (called at a falling edge, return at a falling edge)
  // ---------------------------------------------------------------------------
  task automatic put(input int v, input bit fl);
    bit got;
    got = 0;
    prod_valid = 1'b1;
    prod_data  = PROD_W'(v);
    flush      = fl;
    for (int i = 0; i < 100 && !got; i++) begin
      got = prod_ready;
      @(negedge clk);
    end
    if (!got) check("put_timeout", 0, 1);
    prod_valid = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic idle(input int n);
    prod_valid = 1'b0;
    flush      = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_result(input string name, input int d, input int c,
                               input bit o);
    bit seen;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (acc_valid) seen = 1;
      else @(negedge clk);
    end
    check({name, "_seen"}, seen, 1);
    check({name, "_data"}, acc_data, d);
    check({name, "_cnt"}, acc_cnt, c);
    check({name, "_ovf"}, acc_ovf, o);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int cyc;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_acc_valid", acc_valid, 0);
    check("rst_acc_data", acc_data, 0);
    check("rst_acc_cnt", acc_cnt, 0);
    check("rst_prod_ready", prod_ready, 1);
    rst_n  = 1'b1;
    cmp_on = 1;

    // T1: back-to-back run, sink always ready; result one clock after last term.
    acc_ready = 1'b1;
    put(21, 0); put(21, 0); put(-12, 0); put(30, 0);
    check("t1_latency", acc_valid, 1);
    expect_result("t1", 60, 4, 0);
    idle(2);

    // T2: sink stalls for 5 clocks; result held and input blocked.
    acc_ready = 1'b0;
    put(21, 0); put(21, 0); put(-12, 0); put(30, 0);
    prod_valid = 1'b1;
    prod_data  = 8'sd99;
    for (int i = 0; i < 5; i++) begin
      check("t2_hold_data", acc_data, 60);
      check("t2_hold_ready", prod_ready, 0);
      @(negedge clk);
    end
    acc_ready = 1'b1;
    @(negedge clk);
    prod_valid = 1'b0;
    check("t2_consumed", acc_valid, 0);
    check("t2_ready_back", prod_ready, 1);
    idle(2);

    // T3: flush without a product, then flush together with a product.
    put(35, 0); put(-9, 0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    expect_result("t3a", 26, 2, 0);
    idle(2);
    put(35, 0); put(-9, 0); put(5, 1);
    expect_result("t3b", 31, 3, 0);
    idle(2);
    // flush on an empty run is ignored
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    check("t3_empty_flush", acc_valid, 0);

    // T4: 100+100-128-128 at 8 bits.
    put(100, 0); put(100, 0); put(-128, 0); put(-128, 0);
`ifdef ACC_SAT_EN
    expect_result("t4", -128, 4, 1);
`else
    expect_result("t4", -56, 4, 0);
`endif
    idle(2);

    // T5: reset in the middle of a run discards the partial sum.
    put(50, 0); put(60, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_rst_valid", acc_valid, 0);
    check("t5_rst_data", acc_data, 0);
    check("t5_rst_cnt", acc_cnt, 0);
    check("t5_rst_ovf", acc_ovf, 0);
    rst_n = 1'b1;
    put(1, 0); put(1, 0); put(1, 0); put(1, 0);
    expect_result("t5", 4, 4, 0);
    idle(2);

    // T6: random gaps, flushes and sink stalls over 1000 runs.
    cyc = m_runs;
    for (int i = 0; i < 60000 && m_runs < cyc + 1000; i++) begin
      prod_valid = ($urandom_range(0, 3) != 0);
      prod_data  = PROD_W'($urandom);
      flush      = ($urandom_range(0, 15) == 0);
      acc_ready  = ($urandom_range(0, 2) != 0);
      @(negedge clk);
    end
    check("t6_runs_done", (m_runs >= cyc + 1000), 1);
    prod_valid = 1'b0;
    acc_ready  = 1'b1;
    idle(3);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    idle(3);
    check("t6_conservation", dut_out, dut_in);
    check("t6_terms_model", dut_in, m_terms);

    cmp_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
